lfsr_gen: RTL and testbench
===========================

LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  width_p  6  state width in bits; legal range 3..32.
  taps_p  6'b110000  feedback tap mask, width_p bits.
  reset_val_p  6'b000001  reset seed, width_p bits; must be nonzero.
  mode_p  0  0 = Fibonacci, 1 = Galois.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning), clock and reset first:
  clk_i  in  1  sole clock; all state updates on rising edge.
  reset_i  in  1  synchronous, active-high reset.
  enable_i  in  1  advance the LFSR one step this cycle.
  load_i  in  1  load seed_i into state this cycle.
  seed_i  in  width_p  value loaded when load_i=1.
  data_o  out  width_p  current LFSR state.
  bit_o  out  1  serial output, equal to data_o[width_p-1].
  lockup_o  out  1  one-cycle pulse: all-zero state recovered.
  wrap_o  out  1  one-cycle pulse: state returned to reference seed.
  period_o  out  width_p  step count of the last completed cycle.
REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-high; no other asynchronous inputs.

Function
REQ-004 Fibonacci step (mode_p=0): fb = XOR of s[i] for all i where taps_p[i]=1; next = {s[width_p-2:0], fb}.
REQ-005 Galois step (mode_p=1): next = {s[width_p-2:0],1'b0} XOR ({width_p{s[width_p-1]}} AND taps_p); taps_p[0] must be 1.
REQ-006 Priority each cycle SHALL be reset_i > load_i > enable_i > hold.
REQ-007 load_i=1: state <= seed_i; reference seed <= seed_i; step counter <= 0; lockup_o, wrap_o = 0 the next cycle; period_o unchanged.
REQ-008 Lockup: if enable_i=1, load_i=0 and state == 0, state SHALL become reset_val_p and not the step result; lockup_o SHALL pulse 1 for the next cycle; step counter <= 0; reference seed unchanged.
REQ-009 Normal step: enable_i=1, load_i=0, state != 0: state <= next; step counter <= counter+1.
REQ-010 Wrap: if the stepped next state equals the reference seed, wrap_o SHALL pulse 1 for the next cycle; period_o <= counter+1; step counter <= 0.
REQ-011 The step counter SHALL be width_p bits and saturate at 2^width_p-1, with no wrap-around.
REQ-012 When enable_i=0 and load_i=0, state, counter, period_o and reference seed SHALL hold; lockup_o and wrap_o SHALL be 0.
REQ-013 All outputs SHALL be registered; a step is visible on data_o one cycle after the enabling edge (latency 1).
REQ-014 Simultaneous load_i and enable_i SHALL perform the load only, with no step.

Reset
REQ-015 reset_i=1 SHALL set, at the next edge: state = reset_val_p, reference seed = reset_val_p, counter = 0, period_o = 0, lockup_o = 0, wrap_o = 0.
REQ-016 reset_i asserted mid-sequence, or together with load_i or enable_i, SHALL override both; the first step after release starts from reset_val_p.

Verification
REQ-017 Defaults (W=6, taps 110000, Fibonacci): reset, then enable 7 cycles -> data_o = 000001, 000010, 000100, 001000, 010000, 100001, 000011.
REQ-018 Defaults: enable continuously 63 steps after reset -> wrap_o pulses exactly once, on step 63; period_o = 63; data_o = 000001.
REQ-019 load_i=1 with seed_i=000000, then enable_i=1 -> data_o = 000000, then 000001; lockup_o = 1 for that one cycle; wrap_o = 0.
REQ-020 mode_p=1, taps 000011: load 100000, then enable one step -> data_o = 000011; load 000001, then step -> 000010.
REQ-021 Load 000001 and enable_i=1 in the same cycle -> data_o = 000001 (no step), counter = 0; enable_i=0 for 5 cycles -> all outputs held.
REQ-022 reset_i=1 on step 30 with enable_i=1 -> next data_o = 000001, period_o = 0, wrap_o = 0; resume -> sequence matches REQ-017.

Source files
------------

// File: rtl/lfsr_gen.sv
// Configurable Fibonacci/Galois LFSR with seed load, all-zero lockup recovery,
// and measurement of the step count taken to return to the reference seed.
module lfsr_gen #(
    parameter int unsigned        width_p     = 6,
    parameter logic [width_p-1:0] taps_p      = 6'b110000,
    parameter logic [width_p-1:0] reset_val_p = 6'b000001,
    parameter int unsigned        mode_p      = 0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               enable_i,
    input  logic               load_i,
    input  logic [width_p-1:0] seed_i,
    output logic [width_p-1:0] data_o,
    output logic               bit_o,
    output logic               lockup_o,
    output logic               wrap_o,
    output logic [width_p-1:0] period_o
);

    localparam logic [width_p-1:0] allOnes = '1;

    logic [width_p-1:0] state_q, state_d;
    logic [width_p-1:0] seedRef_q, seedRef_d;
    logic [width_p-1:0] count_q, count_d;
    logic [width_p-1:0] period_q, period_d;
    logic               lockup_q, lockup_d;
    logic               wrap_q, wrap_d;
    logic [width_p-1:0] stepVal;
    logic [width_p-1:0] countInc;

    // One LFSR step from the current state; the topology is fixed at elaboration.
    generate
        if (mode_p == 0) begin : g_fib
            always_comb stepVal = {state_q[width_p-2:0], ^(state_q & taps_p)};
        end else begin : g_gal
            always_comb stepVal = {state_q[width_p-2:0], 1'b0}
                                ^ ({width_p{state_q[width_p-1]}} & taps_p);
        end
    endgenerate

    assign countInc = (count_q == allOnes) ? count_q : count_q + width_p'(1);

    always_comb begin
        state_d   = state_q;
        seedRef_d = seedRef_q;
        count_d   = count_q;
        period_d  = period_q;
        lockup_d  = 1'b0;
        wrap_d    = 1'b0;
        if (load_i) begin
            state_d   = seed_i;
            seedRef_d = seed_i;
            count_d   = '0;
        end else if (enable_i) begin
            // An all-zero state would never leave zero, so reseed instead of stepping.
            if (state_q == '0) begin
                state_d  = reset_val_p;
                lockup_d = 1'b1;
                count_d  = '0;
            end else begin
                state_d = stepVal;
                if (stepVal == seedRef_q) begin
                    wrap_d   = 1'b1;
                    period_d = countInc;
                    count_d  = '0;
                end else begin
                    count_d = countInc;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= reset_val_p;
            seedRef_q <= reset_val_p;
            count_q   <= '0;
            period_q  <= '0;
            lockup_q  <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            seedRef_q <= seedRef_d;
            count_q   <= count_d;
            period_q  <= period_d;
            lockup_q  <= lockup_d;
            wrap_q    <= wrap_d;
        end
    end

    assign data_o   = state_q;
    assign bit_o    = state_q[width_p-1];
    assign lockup_o = lockup_q;
    assign wrap_o   = wrap_q;
    assign period_o = period_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: a Fibonacci and a Galois instance share stimulus and are
// compared every cycle against an integer model, plus fixed reference sequences.
module tb_lfsr_gen;

    logic       clk = 1'b0;
    logic       resetIn = 1'b1;
    logic       enableIn = 1'b0;
    logic       loadIn = 1'b0;
    logic [5:0] seedIn = '0;

    logic [5:0] dataF, periodF, dataG, periodG;
    logic       bitF, lockF, wrapF, bitG, lockG, wrapG;

    int vectors = 0;
    int miscompares = 0;
    bit modelValid = 0;

    // model state per instance: 0 = Fibonacci default, 1 = Galois taps 000011
    int mState[2], mRef[2], mCount[2], mPeriod[2];
    bit mLock[2], mWrap[2];
    int tapsM[2] = '{48, 3};
    int modeM[2] = '{0, 1};

    always #5 clk = ~clk;

    lfsr_gen dutF (
        .clk_i(clk), .reset_i(resetIn), .enable_i(enableIn), .load_i(loadIn),
        .seed_i(seedIn), .data_o(dataF), .bit_o(bitF), .lockup_o(lockF),
        .wrap_o(wrapF), .period_o(periodF)
    );

    lfsr_gen #(
        .width_p(6), .taps_p(6'b000011), .reset_val_p(6'b000001), .mode_p(1)
    ) dutG (
        .clk_i(clk), .reset_i(resetIn), .enable_i(enableIn), .load_i(loadIn),
        .seed_i(seedIn), .data_o(dataG), .bit_o(bitG), .lockup_o(lockG),
        .wrap_o(wrapG), .period_o(periodG)
    );

    function automatic int nextOf(input int idx, input int s);
        int fb;
        int r;
        if (modeM[idx] == 0) begin
            fb = 0;
            for (int i = 0; i < 6; i++)
                if (((tapsM[idx] >> i) & 1) == 1) fb = fb ^ ((s >> i) & 1);
            r = ((s * 2) % 64) + fb;
        end else begin
            r = (s * 2) % 64;
            if (s >= 32) r = r ^ tapsM[idx];
        end
        return r;
    endfunction

    function automatic int satInc(input int c);
        return (c + 1 > 63) ? 63 : c + 1;
    endfunction

    task automatic modelStep(input int idx, input bit rst, input bit ld, input bit en, input int seed);
        int nxt;
        mLock[idx] = 0;
        mWrap[idx] = 0;
        if (rst) begin
            mState[idx] = 1; mRef[idx] = 1; mCount[idx] = 0; mPeriod[idx] = 0;
        end else if (ld) begin
            mState[idx] = seed; mRef[idx] = seed; mCount[idx] = 0;
        end else if (en) begin
            if (mState[idx] == 0) begin
                mState[idx] = 1; mLock[idx] = 1; mCount[idx] = 0;
            end else begin
                nxt = nextOf(idx, mState[idx]);
                if (nxt == mRef[idx]) begin
                    mWrap[idx] = 1;
                    mPeriod[idx] = satInc(mCount[idx]);
                    mCount[idx] = 0;
                end else begin
                    mCount[idx] = satInc(mCount[idx]);
                end
                mState[idx] = nxt;
            end
        end
    endtask

    task automatic compareOne(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput();
        compareOne("fib.data",   int'(dataF),   mState[0]);
        compareOne("fib.bit",    int'(bitF),    (mState[0] >> 5) & 1);
        compareOne("fib.lockup", int'(lockF),   int'(mLock[0]));
        compareOne("fib.wrap",   int'(wrapF),   int'(mWrap[0]));
        compareOne("fib.period", int'(periodF), mPeriod[0]);
        compareOne("gal.data",   int'(dataG),   mState[1]);
        compareOne("gal.bit",    int'(bitG),    (mState[1] >> 5) & 1);
        compareOne("gal.lockup", int'(lockG),   int'(mLock[1]));
        compareOne("gal.wrap",   int'(wrapG),   int'(mWrap[1]));
        compareOne("gal.period", int'(periodG), mPeriod[1]);
    endtask

    // Single compare process: every cycle once the model has been initialised.
    always @(negedge clk) begin
        if (modelValid) checkOutput();
    end

    task automatic applyStimulus(input bit rst, input bit ld, input bit en, input logic [5:0] seed);
        resetIn  = rst;
        loadIn   = ld;
        enableIn = en;
        seedIn   = seed;
        @(posedge clk);
        modelStep(0, rst, ld, en, int'(seed));
        modelStep(1, rst, ld, en, int'(seed));
        modelValid = 1;
        @(negedge clk);
        #1;
    endtask

    int fibRef[7] = '{1, 2, 4, 8, 16, 33, 3};
    int wrapCount;

    initial begin
        // reset and the reference Fibonacci sequence
        applyStimulus(1, 0, 0, 6'd0);
        applyStimulus(1, 0, 0, 6'd0);
        compareOne("lit.resetData", int'(dataF), 1);
        compareOne("lit.resetPeriod", int'(periodF), 0);
        for (int k = 1; k < 7; k++) begin
            applyStimulus(0, 0, 1, 6'd0);
            compareOne("lit.fibSeq", int'(dataF), fibRef[k]);
        end

        // full period: exactly one wrap, on step 63
        wrapCount = 0;
        for (int k = 7; k <= 63; k++) begin
            applyStimulus(0, 0, 1, 6'd0);
            if (wrapF) wrapCount++;
        end
        compareOne("lit.wrapStep63", int'(wrapF), 1);
        compareOne("lit.wrapOnce", wrapCount, 1);
        compareOne("lit.period63", int'(periodF), 63);
        compareOne("lit.wrapData", int'(dataF), 1);

        // zero seed then lockup recovery
        applyStimulus(0, 1, 0, 6'd0);
        compareOne("lit.zeroLoad", int'(dataF), 0);
        compareOne("lit.loadKeepsPeriod", int'(periodF), 63);
        applyStimulus(0, 0, 1, 6'd0);
        compareOne("lit.lockData", int'(dataF), 1);
        compareOne("lit.lockPulse", int'(lockF), 1);
        compareOne("lit.lockNoWrap", int'(wrapF), 0);
        applyStimulus(0, 0, 1, 6'd0);
        compareOne("lit.lockOneCycle", int'(lockF), 0);

        // load wins over enable, then hold
        applyStimulus(0, 1, 1, 6'd1);
        compareOne("lit.loadNoStep", int'(dataF), 1);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 0, 0, 6'($urandom_range(0, 63)));
            compareOne("lit.holdData", int'(dataF), 1);
        end

        // reset on step 30 together with enable, then resume
        applyStimulus(1, 0, 0, 6'd0);
        for (int k = 1; k < 30; k++) applyStimulus(0, 0, 1, 6'd0);
        applyStimulus(1, 0, 1, 6'd0);
        compareOne("lit.midReset", int'(dataF), 1);
        compareOne("lit.midResetPeriod", int'(periodF), 0);
        compareOne("lit.midResetWrap", int'(wrapF), 0);
        for (int k = 1; k < 7; k++) begin
            applyStimulus(0, 0, 1, 6'd0);
            compareOne("lit.resumeSeq", int'(dataF), fibRef[k]);
        end

        // Galois reference steps
        applyStimulus(0, 1, 0, 6'b100000);
        applyStimulus(0, 0, 1, 6'd0);
        compareOne("lit.galStep1", int'(dataG), 3);
        applyStimulus(0, 1, 0, 6'b000001);
        applyStimulus(0, 0, 1, 6'd0);
        compareOne("lit.galStep2", int'(dataG), 2);

        // random seeds followed by long enable runs to exercise wrap/period
        for (int r = 0; r < 6; r++) begin
            applyStimulus(0, 1, 0, 6'($urandom_range(1, 63)));
            for (int k = 0; k < 70; k++) applyStimulus(0, 0, ($urandom_range(0, 7) != 0), 6'd0);
        end

        // fully random traffic
        for (int k = 0; k < 3000; k++) begin
            applyStimulus(($urandom_range(0, 63) == 0),
                          ($urandom_range(0, 15) == 0),
                          ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(0, 63)));
        end

        modelValid = 0;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
